// File: rtl/jaxa_rx_fifo_reader_if.sv
// Receive character stream from the SpaceWire codec into the RX FIFO.
// 9-bit characters: [8] marks EOP/EEP, [7:0] data or end-marker code.
interface jaxa_rx_fifo_reader_if;
   logic [8:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );
endinterface

// File: rtl/jaxa_rx_fifo_reader.sv
// RX character FIFO between the SpaceWire codec and the Avalon PIO in_port.
// Head character is shown continuously; each pop_req rise pops one entry.
module jaxa_rx_fifo_reader #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   jaxa_rx_fifo_reader_if.slave  rx,
   input  logic                  pop_req,
   output logic [8:0]            out_data,
   output logic                  out_valid,
   output logic [AW:0]           level,
   output logic                  overflow,
   input  logic                  clr_overflow
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_d;
   logic          pop_pulse;
   logic          push;
   logic          pop;
   logic [AW:0]   level_next;

   assign pop_pulse = pop_req & ~pop_d;
   assign push      = rx.rx_valid & rx.rx_ready;
   // A pop request against an empty FIFO is simply lost
   assign pop       = pop_pulse & out_valid;

   always_comb begin
      level_next = level;
      unique case (1'b1)
         push & ~pop: level_next = level + 1'b1;
         pop & ~push: level_next = level - 1'b1;
         default:     level_next = level;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         pop_d       <= 1'b0;
         rx.rx_ready <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pop_d       <= pop_req;
         level       <= level_next;
         rx.rx_ready <= (level_next != LVL_FULL);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // Set has priority so a drop in the clearing cycle is not lost
         if (rx.rx_valid & ~rx.rx_ready) overflow <= 1'b1;
         else if (clr_overflow)          overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx.rx_data;
   end

   assign out_valid = (level != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : 9'h000;

endmodule
